hw_thread_scheduler: RTL and testbench
======================================

Name: hw_thread_scheduler

Overview:
Coarse-grained hardware-thread scheduler for the OOO core front end. Picks which hardware thread owns fetch. On quantum expiry, a long stall or a yield it switches threads in four steps: gate fetch (scheduler_en), drain the backend, swap the fetch PC, resume. It tracks a per-thread resume PC from commit and drives the fetch unit's hardware_scheduler_en / hardware_scheduler_swap_pc / hardware_scheduler_pc inputs.

Parameters:
NUM_THREADS, 2, number of hardware threads (2..8)
QUANTUM, 256, RUN cycles before a forced switch (>=2)
DRAIN_CYCLES, 4, minimum cycles spent in DRAIN, covering fetch/IQ latency (>=1)
RESET_PC_BASE, 32'h1eceb000, reset resume PC of thread 0
RESET_PC_STRIDE, 32'h00010000, reset PC of thread i = BASE + i*STRIDE

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
thread_en  in  NUM_THREADS  per-thread runnable mask
commit_valid  in  1  instruction of the active thread commits this cycle
commit_next_pc  in  32  architectural next PC of the committing instruction
long_stall  in  1  active thread blocked on a long-latency event, e.g. dcache miss
yield_req  in  1  software/decoder request to yield, single-cycle pulse
rob_empty  in  1  backend holds no in-flight instructions
hardware_scheduler_en  out  1  fetch gate: blocks IQ writes
hardware_scheduler_swap_pc  out  1  one-cycle pulse that loads hardware_scheduler_pc into the fetch PC
hardware_scheduler_pc  out  32  resume PC of the incoming thread
active_thread  out  $clog2(NUM_THREADS)  thread currently owning fetch
switch_count  out  32  completed switches (see Optional Feature)

Behaviour:
- Reset (rst low, async):
  - state=RUN, active_thread=0, quantum counter=0, drain counter=0.
  - resume_pc[i]=RESET_PC_BASE+i*RESET_PC_STRIDE.
  - All outputs 0 except hardware_scheduler_pc=RESET_PC_BASE.
- Resume-PC tracking: resume_pc[active_thread] <= commit_next_pc on commit_valid. This applies in every state except SWAP.
- next_tid: first set bit of thread_en scanning active_thread+1 upward, modulo NUM_THREADS, excluding active_thread. other_ready=1 when one exists.
- switch trigger: (qcnt==QUANTUM-1) | long_stall | yield_req | ~thread_en[active_thread].
- RUN:
  - Outputs: scheduler_en=0, swap_pc=0.
  - qcnt increments each cycle.
  - trigger & other_ready -> DRAIN; latch target=next_tid; qcnt<=0; dcnt<=0.
  - trigger & ~other_ready -> stay in RUN; qcnt<=0 on expiry (wrap); yield and long_stall are dropped.
  - Simultaneous triggers produce a single switch.
- DRAIN:
  - scheduler_en=1 (fetch writes no new IQ entries).
  - dcnt saturates at DRAIN_CYCLES.
  - Exit to SWAP when dcnt>=DRAIN_CYCLES-1 and rob_empty are true in the same cycle.
  - Triggers and flush are ignored here.
  - If thread_en[target] drops, re-pick target=next_tid. If none remain, return to RUN with no swap.
- SWAP (1 cycle):
  - scheduler_en=1, swap_pc=1, hardware_scheduler_pc=resume_pc[target].
  - active_thread<=target. Next state RESUME.
- RESUME (1 cycle):
  - scheduler_en=0, which lets the fetch unit clear its stale read-address tracking.
  - qcnt<=0, then RUN.
- hardware_scheduler_pc holds its last SWAP value outside SWAP.
- Minimum switch latency is DRAIN_CYCLES+2 cycles from the trigger.
- Reset asserted mid-DRAIN or mid-SWAP returns to the reset state. No swap pulse is emitted.
- qcnt width is $clog2(QUANTUM). There is no overflow because it wraps or clears at QUANTUM-1.

Optional Feature:
Macro SCHED_PERF_CNT_EN.
- Defined: switch_count increments by 1 on each SWAP cycle and wraps at 2^32. Reset to 0.
- Undefined: switch_count tied to 0 and no counter flops are built. All other ports and behaviour are identical.

Test Plan:
- Reset values, QUANTUM=8, thread_en=2'b11, rob_empty=1 -> hardware_scheduler_pc=32'h1eceb000, active_thread=0, all enables 0 at reset.
- No other trigger -> scheduler_en rises on cycle 8. With DRAIN_CYCLES=4, swap_pc pulses on cycle 12 with pc=32'h1ecfb000, and active_thread=1.
- Commit tracking: commit_valid with commit_next_pc=32'h1eceb040, then long_stall=1 -> switch to thread 1. A later switch back -> swap_pc pulse carries 32'h1eceb040.
- thread_en=2'b01 with long_stall held and the quantum expiring -> scheduler_en stays 0, no swap pulse, active_thread=0, qcnt wraps.
- rob_empty held 0 for 20 cycles in DRAIN -> scheduler_en stays 1, no swap. rob_empty rises -> swap_pc on the next cycle.
- rst pulsed low during DRAIN -> scheduler_en=0 immediately (async). active_thread=0, no swap pulse. With SCHED_PERF_CNT_EN, switch_count=0.

Source files
------------

// File: rtl/hw_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hw_thread_scheduler
// Brief    : Coarse-grained HW thread scheduler: gate fetch, drain, swap PC,
//            resume. Optional macro SCHED_PERF_CNT_EN builds switch_count.
// Revision : 1.0  initial release
// ============================================================================
module hw_thread_scheduler #(
  parameter int          NUM_THREADS     = 2,
  parameter int          QUANTUM         = 256,
  parameter int          DRAIN_CYCLES    = 4,
  parameter logic [31:0] RESET_PC_BASE   = 32'h1eceb000,
  parameter logic [31:0] RESET_PC_STRIDE = 32'h00010000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_THREADS-1:0]         thread_en,
  input  logic                           commit_valid,
  input  logic [31:0]                    commit_next_pc,
  input  logic                           long_stall,
  input  logic                           yield_req,
  input  logic                           rob_empty,
  output logic                           hardware_scheduler_en,
  output logic                           hardware_scheduler_swap_pc,
  output logic [31:0]                    hardware_scheduler_pc,
  output logic [$clog2(NUM_THREADS)-1:0] active_thread,
  output logic [31:0]                    switch_count
);

  localparam int c_tid_w  = $clog2(NUM_THREADS);
  localparam int c_qcnt_w = $clog2(QUANTUM);
  localparam int c_dcnt_w = $clog2(DRAIN_CYCLES + 1);

  localparam logic [c_qcnt_w-1:0] c_q_last = c_qcnt_w'(QUANTUM - 1);
  localparam logic [c_dcnt_w-1:0] c_d_last = c_dcnt_w'(DRAIN_CYCLES - 1);
  localparam logic [c_dcnt_w-1:0] c_d_max  = c_dcnt_w'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWAP   = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [c_tid_w-1:0]    active_q, active_d;
  logic [c_tid_w-1:0]    target_q, target_d;
  logic [c_qcnt_w-1:0]   qcnt_q, qcnt_d;
  logic [c_dcnt_w-1:0]   dcnt_q, dcnt_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           resume_pc_q [NUM_THREADS];
  logic [31:0]           resume_pc_d [NUM_THREADS];

  logic [c_tid_w-1:0]    next_tid;
  logic                  other_ready;
  logic                  trigger;

  function automatic logic [c_tid_w-1:0] wrap_tid(input logic [c_tid_w-1:0] base,
                                                  input int off);
    int idx;
    idx = int'(base) + off;
    if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
    return c_tid_w'(idx);
  endfunction

  // Scan from the farthest offset down so the nearest runnable thread wins.
  always_comb begin
    next_tid    = active_q;
    other_ready = 1'b0;
    for (int off = NUM_THREADS - 1; off >= 1; off--) begin
      if (thread_en[wrap_tid(active_q, off)]) begin
        next_tid    = wrap_tid(active_q, off);
        other_ready = 1'b1;
      end
    end
  end

  assign trigger = (qcnt_q == c_q_last) | long_stall | yield_req | ~thread_en[active_q];

  always_comb begin
    state_d                    = state_q;
    active_d                   = active_q;
    target_d                   = target_q;
    qcnt_d                     = qcnt_q;
    dcnt_d                     = dcnt_q;
    pc_d                       = pc_q;
    hardware_scheduler_en      = 1'b0;
    hardware_scheduler_swap_pc = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) resume_pc_d[i] = resume_pc_q[i];

    // During SWAP ownership is changing hands, so commits are not attributed.
    if (commit_valid && (state_q != ST_SWAP)) resume_pc_d[active_q] = commit_next_pc;

    case (state_q)
      ST_RUN: begin
        qcnt_d = (qcnt_q == c_q_last) ? '0 : qcnt_q + 1'b1;
        if (trigger && other_ready) begin
          state_d  = ST_DRAIN;
          target_d = next_tid;
          qcnt_d   = '0;
          dcnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        hardware_scheduler_en = 1'b1;
        if (dcnt_q != c_d_max) dcnt_d = dcnt_q + 1'b1;
        // A target that became unrunnable must never be swapped in.
        if (!thread_en[target_q]) begin
          if (other_ready) target_d = next_tid;
          else             state_d  = ST_RUN;
        end else if ((dcnt_q >= c_d_last) && rob_empty) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        hardware_scheduler_en      = 1'b1;
        hardware_scheduler_swap_pc = 1'b1;
        active_d                   = target_q;
        pc_d                       = resume_pc_q[target_q];
        state_d                    = ST_RESUME;
      end
      ST_RESUME: begin
        qcnt_d  = '0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      active_q <= '0;
      target_q <= '0;
      qcnt_q   <= '0;
      dcnt_q   <= '0;
      pc_q     <= RESET_PC_BASE;
      for (int i = 0; i < NUM_THREADS; i++)
        resume_pc_q[i] <= RESET_PC_BASE + 32'(i) * RESET_PC_STRIDE;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      target_q <= target_d;
      qcnt_q   <= qcnt_d;
      dcnt_q   <= dcnt_d;
      pc_q     <= pc_d;
      for (int i = 0; i < NUM_THREADS; i++) resume_pc_q[i] <= resume_pc_d[i];
    end
  end

  assign hardware_scheduler_pc = (state_q == ST_SWAP) ? resume_pc_q[target_q] : pc_q;
  assign active_thread         = active_q;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] switch_count_q, switch_count_d;

  always_comb begin
    switch_count_d = switch_count_q;
    if (state_q == ST_SWAP) switch_count_d = switch_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) switch_count_q <= '0;
    else      switch_count_q <= switch_count_d;
  end

  assign switch_count = switch_count_q;
`else
  assign switch_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hw_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hw_thread_scheduler
// Brief    : Directed, table-driven bench for hw_thread_scheduler
//            (QUANTUM=8, DRAIN_CYCLES=4, two threads).
// Revision : 1.0  initial release
// ============================================================================
module tb_hw_thread_scheduler;

  localparam logic [31:0] PC0 = 32'h1eceb000;
  localparam logic [31:0] PC1 = 32'h1ecfb000;
  localparam logic [31:0] PCA = 32'h1eceb040;
  localparam logic [31:0] PCB = 32'h1ecfb080;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  thread_en;
  logic        commit_valid;
  logic [31:0] commit_next_pc;
  logic        long_stall;
  logic        yield_req;
  logic        rob_empty;
  logic        sched_en;
  logic        swap_pc;
  logic [31:0] sched_pc;
  logic [0:0]  active_thread;
  logic [31:0] switch_count;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_sc = 32'd0;

  always #5 clk = ~clk;

  hw_thread_scheduler #(
    .NUM_THREADS (2),
    .QUANTUM     (8),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .thread_en                 (thread_en),
    .commit_valid              (commit_valid),
    .commit_next_pc            (commit_next_pc),
    .long_stall                (long_stall),
    .yield_req                 (yield_req),
    .rob_empty                 (rob_empty),
    .hardware_scheduler_en     (sched_en),
    .hardware_scheduler_swap_pc(swap_pc),
    .hardware_scheduler_pc     (sched_pc),
    .active_thread             (active_thread),
    .switch_count              (switch_count)
  );

  typedef struct {
    logic [1:0]  te;
    logic        cv;
    logic [31:0] cpc;
    logic        ls;
    logic        yr;
    logic        re;
    int          n;
    logic        en;
    logic        sw;
    logic [31:0] pc;
    logic        tid;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic [1:0] te, logic cv, logic [31:0] cpc, logic ls,
                              logic yr, logic re, int n, logic en, logic sw,
                              logic [31:0] pc, logic tid);
    vec_t v;
    v.te = te; v.cv = cv; v.cpc = cpc; v.ls = ls; v.yr = yr; v.re = re; v.n = n;
    v.en = en; v.sw = sw; v.pc = pc; v.tid = tid;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic en, input logic sw,
                            input logic [31:0] pc, input logic tid);
    check({tag, ".en"},  32'(sched_en),      32'(en));
    check({tag, ".sw"},  32'(swap_pc),       32'(sw));
    check({tag, ".pc"},  sched_pc,           pc);
    check({tag, ".tid"}, 32'(active_thread), 32'(tid));
    check({tag, ".sc"},  switch_count,       exp_sc);
  endtask

  task automatic note_swap(input logic sw);
`ifdef SCHED_PERF_CNT_EN
    if (sw) exp_sc = exp_sc + 32'd1;
`else
    if (sw) exp_sc = exp_sc;
`endif
  endtask

  task automatic drive(input logic [1:0] te, input logic cv, input logic [31:0] cpc,
                       input logic ls, input logic yr, input logic re);
    thread_en = te; commit_valid = cv; commit_next_pc = cpc;
    long_stall = ls; yield_req = yr; rob_empty = re;
  endtask

  // Leaves the bench at a negedge with reset released: cycle 0 starts here.
  task automatic do_reset();
    rst = 1'b0;
    drive(2'b11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    exp_sc = 32'd0;
    check_outs("reset", 1'b0, 1'b0, PC0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // te cv cpc ls yr re n | en sw pc tid
    vecs[0]  = mk(2'b11, 0, 32'h0, 0, 0, 1, 3, 0, 0, PC0, 0);
    vecs[1]  = mk(2'b11, 1, PCA,   0, 0, 1, 1, 0, 0, PC0, 0);
    vecs[2]  = mk(2'b11, 0, 32'h0, 0, 0, 1, 4, 0, 0, PC0, 0);
    vecs[3]  = mk(2'b11, 0, 32'h0, 0, 0, 1, 4, 1, 0, PC0, 0);
    vecs[4]  = mk(2'b11, 0, 32'h0, 0, 0, 1, 1, 1, 1, PC1, 0);
    vecs[5]  = mk(2'b11, 0, 32'h0, 0, 0, 1, 1, 0, 0, PC1, 1);
    vecs[6]  = mk(2'b11, 1, PCB,   0, 0, 1, 1, 0, 0, PC1, 1);
    vecs[7]  = mk(2'b11, 0, 32'h0, 1, 0, 1, 1, 0, 0, PC1, 1);
    vecs[8]  = mk(2'b11, 0, 32'h0, 0, 0, 1, 4, 1, 0, PC1, 1);
    vecs[9]  = mk(2'b11, 0, 32'h0, 0, 0, 1, 1, 1, 1, PCA, 1);
    vecs[10] = mk(2'b11, 0, 32'h0, 0, 0, 1, 1, 0, 0, PCA, 0);
    vecs[11] = mk(2'b11, 0, 32'h0, 0, 1, 1, 1, 0, 0, PCA, 0);
    vecs[12] = mk(2'b11, 0, 32'h0, 0, 0, 1, 4, 1, 0, PCA, 0);
    vecs[13] = mk(2'b11, 0, 32'h0, 0, 0, 1, 1, 1, 1, PCB, 0);
    vecs[14] = mk(2'b11, 0, 32'h0, 0, 0, 1, 1, 0, 0, PCB, 1);
    vecs[15] = mk(2'b01, 0, 32'h0, 0, 0, 1, 1, 0, 0, PCB, 1);
    vecs[16] = mk(2'b01, 0, 32'h0, 0, 0, 1, 4, 1, 0, PCB, 1);
    vecs[17] = mk(2'b01, 0, 32'h0, 0, 0, 1, 1, 1, 1, PCA, 1);
    vecs[18] = mk(2'b01, 0, 32'h0, 0, 0, 1, 1, 0, 0, PCA, 0);

    // Quantum expiry, commit tracking, long stall, yield, active-thread disable.
    do_reset();
    for (int k = 0; k < 19; k++) begin
      for (int r = 0; r < vecs[k].n; r++) begin
        check_outs($sformatf("v%0d.%0d", k, r), vecs[k].en, vecs[k].sw, vecs[k].pc, vecs[k].tid);
        note_swap(vecs[k].sw);
        drive(vecs[k].te, vecs[k].cv, vecs[k].cpc, vecs[k].ls, vecs[k].yr, vecs[k].re);
        @(negedge clk);
      end
    end

    // Only one runnable thread: stall and expiry are dropped, quantum wraps.
    do_reset();
    drive(2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      check_outs($sformatf("solo.%0d", c), 1'b0, 1'b0, PC0, 1'b0);
      @(negedge clk);
    end
    drive(2'b11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int c = 20; c < 24; c++) begin
      check_outs($sformatf("wrap.%0d", c), 1'b0, 1'b0, PC0, 1'b0);
      @(negedge clk);
    end
    check_outs("wrap.24", 1'b1, 1'b0, PC0, 1'b0);

    // Backend never empties: stay in DRAIN until rob_empty rises.
    do_reset();
    drive(2'b11, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_outs("rob.0", 1'b0, 1'b0, PC0, 1'b0);
    @(negedge clk);
    yield_req = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      check_outs($sformatf("rob.%0d", c), 1'b1, 1'b0, PC0, 1'b0);
      if (c == 21) rob_empty = 1'b1;
      @(negedge clk);
    end
    check_outs("rob.22", 1'b1, 1'b1, PC1, 1'b0);
    note_swap(1'b1);
    @(negedge clk);
    check_outs("rob.23", 1'b0, 1'b0, PC1, 1'b1);

    // Target drops out during DRAIN with no alternative: back to RUN, no swap.
    do_reset();
    drive(2'b11, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    yield_req = 1'b0;
    check_outs("drop.1", 1'b1, 1'b0, PC0, 1'b0);
    thread_en = 2'b01;
    @(negedge clk);
    rob_empty = 1'b1;
    for (int c = 2; c < 6; c++) begin
      check_outs($sformatf("drop.%0d", c), 1'b0, 1'b0, PC0, 1'b0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of DRAIN.
    do_reset();
    drive(2'b11, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    yield_req = 1'b0;
    check_outs("arst.pre", 1'b1, 1'b0, PC0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    exp_sc = 32'd0;
    #1;
    check_outs("arst.now", 1'b0, 1'b0, PC0, 1'b0);
    rob_empty = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_outs($sformatf("arst.%0d", c), 1'b0, 1'b0, PC0, 1'b0);
    end
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
